// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate block tester: FSM encoding, vector sizing
// and the expected response of the gate block (S1 = A AND B, S2 = NOT C).
package gate_tester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int ERR_W   = 4;

    // Returns {exp_s1, exp_s2} for a vector laid out as {a, b, c}.
    function automatic logic [1:0] exp_resp(input logic [VEC_W-1:0] vec);
        return {vec[2] & vec[1], ~vec[0]};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the gate block, indexed by test vector {a, b, c}.
module gate_ref_model
    import gate_tester_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_s1,
    output logic             exp_s2
);

    logic [1:0] resp;

    assign resp   = exp_resp(vec);
    assign exp_s1 = resp[1];
    assign exp_s2 = resp[0];

endmodule

// File: rtl/gate_tester.sv
// Walks all 8 {a,b,c} vectors into the gate block and checks s1/s2 responses.
// Optional macro GATE_TESTER_LOOP_EN: restart automatically after every run.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       s1,
    input  logic       s2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_mask
);

`ifdef GATE_TESTER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t               state;
    state_t               state_next;
    logic [VEC_W-1:0]     vec;
    logic [7:0]           settle_cnt;
    logic [ERR_W-1:0]     err_q;
    logic [ERR_W-1:0]     err_next;
    logic [NUM_VEC-1:0]   mask_q;
    logic                 pass_q;
    logic                 exp_s1;
    logic                 exp_s2;
    logic                 mismatch;
    logic                 settle_end;
    logic                 last_vec;
    logic                 restart;

    gate_ref_model u_ref (
        .vec    (vec),
        .exp_s1 (exp_s1),
        .exp_s2 (exp_s2)
    );

    assign settle_end = (settle_cnt == 8'(SETTLE_CYCLES - 1));
    assign last_vec   = (vec == VEC_W'(NUM_VEC - 1));
    assign mismatch   = (state == CHECK) && ((s1 != exp_s1) || (s2 != exp_s2));
    assign err_next   = err_q + ERR_W'(mismatch);
    // In loop mode DONE lasts exactly one cycle before the next run begins.
    assign restart    = ((state == IDLE) && start) ||
                        ((state == DONE) && (start || LOOP_EN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (restart) state_next = SETTLE;
            SETTLE:  if (settle_end) state_next = CHECK;
            CHECK:   state_next = last_vec ? DONE : SETTLE;
            DONE:    if (restart) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_q      <= '0;
            mask_q     <= '0;
            pass_q     <= 1'b0;
        end else if (restart) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_q      <= '0;
            mask_q     <= '0;
            // Single-shot runs drop the old verdict; loop runs hold it until the next DONE.
            if (!LOOP_EN) begin
                pass_q <= 1'b0;
            end
        end else begin
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 8'd1;
            end
            if (state == CHECK) begin
                err_q <= err_next;
                if (mismatch) begin
                    mask_q[vec] <= 1'b1;
                end
                if (last_vec) begin
                    pass_q <= (err_next == '0);
                end else begin
                    vec        <= vec + VEC_W'(1);
                    settle_cnt <= '0;
                end
            end
        end
    end

    assign a         = vec[2];
    assign b         = vec[1];
    assign c         = vec[0];
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;

endmodule
